// File: rtl/mux_4t1_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter:
// FSM encodings, requester count and the rotating winner search.
package mux_4t1_rr_arbiter_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // First set bit of req scanning start, start+1, ... (mod 4).
    function automatic logic [1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [1:0]       start
    );
        logic [1:0] idx;
        rr_pick = start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/mux_4t1_rr_arbiter_mux.sv
// W-wide 4-to-1 datapath multiplexer steered by the arbiter select.
module mux_4t1_w #(
    parameter int W = 1
) (
    input  logic [W-1:0] I0,
    input  logic [W-1:0] I1,
    input  logic [W-1:0] I2,
    input  logic [W-1:0] I3,
    input  logic [1:0]   Sel,
    output logic [W-1:0] S
);

    always_comb begin
        S = I0;
        unique case (Sel)
            2'd0: S = I0;
            2'd1: S = I1;
            2'd2: S = I2;
            2'd3: S = I3;
        endcase
    end

endmodule

// File: rtl/mux_4t1_rr_arbiter.sv
// Round-robin arbiter sharing one 4-to-1 mux among four requesters.
// Optional grant hold limit enabled by defining ARB_HOLD_LIMIT_EN.
module mux_4t1_rr_arbiter
    import mux_4t1_rr_arbiter_pkg::*;
#(
    parameter int W        = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] Req,
    input  logic [W-1:0]     I0,
    input  logic [W-1:0]     I1,
    input  logic [W-1:0]     I2,
    input  logic [W-1:0]     I3,
    output logic [N_REQ-1:0] Gnt,
    output logic [1:0]       Sel,
    output logic             Valid,
    output logic [W-1:0]     S
);

    state_t           r_state;
    state_t           w_state_nx;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nx;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nx;
    logic             r_valid;
    logic             w_valid_nx;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_others;
    logic             w_new;
    logic             w_limit;
    logic [W-1:0]     w_mux;

    assign w_others = Req & ~(N_REQ'(1) << r_sel);

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(MAX_HOLD) + 1;

    logic [CW-1:0] r_cnt;
    logic          w_cnt_top;

    assign w_cnt_top = (r_cnt == CW'(MAX_HOLD - 1));
    assign w_limit   = (r_state == ST_GRANT) && w_cnt_top && (|w_others);

    // Saturates at the limit so a lone owner keeps its grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_new) begin
            r_cnt <= '0;
        end else if (r_state == ST_GRANT && !w_cnt_top) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
`else
    logic w_unused_hold;

    assign w_unused_hold = (MAX_HOLD > 0);
    assign w_limit       = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_sel_nx   = r_sel;
        w_valid_nx = r_valid;
        w_new      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (|Req) begin
                    w_sel_nx   = rr_pick(Req, r_ptr);
                    w_valid_nx = 1'b1;
                    w_new      = 1'b1;
                    w_state_nx = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Release or forced revoke: rearbitrate from owner+1.
                if (!Req[r_sel] || w_limit) begin
                    w_ptr_nx = r_sel + 2'd1;
                    if (|w_others) begin
                        w_sel_nx = rr_pick(w_others, r_sel + 2'd1);
                        w_new    = 1'b1;
                    end else begin
                        w_valid_nx = 1'b0;
                        w_state_nx = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_valid <= 1'b0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_sel   <= w_sel_nx;
            r_valid <= w_valid_nx;
            r_gnt   <= w_valid_nx ? (N_REQ'(1) << w_sel_nx) : '0;
        end
    end

    mux_4t1_w #(
        .W(W)
    ) u_mux (
        .I0 (I0),
        .I1 (I1),
        .I2 (I2),
        .I3 (I3),
        .Sel(r_sel),
        .S  (w_mux)
    );

    assign Gnt   = r_gnt;
    assign Sel   = r_sel;
    assign Valid = r_valid;
    assign S     = r_valid ? w_mux : '0;

endmodule

// File: tb/tb_mux_4t1_rr_arbiter.sv
// Bench for mux_4t1_rr_arbiter: owner/pointer model checked every cycle
// plus directed scenarios with literal expectations.
module tb_mux_4t1_rr_arbiter;

    localparam int W  = 4;
    localparam int MH = 4;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   Req;
    logic [W-1:0] I0, I1, I2, I3;
    logic [3:0]   Gnt;
    logic [1:0]   Sel;
    logic         Valid;
    logic [W-1:0] S;

    int n_pass = 0;
    int n_tot  = 0;

    mux_4t1_rr_arbiter #(
        .W(W),
        .MAX_HOLD(MH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .Req  (Req),
        .I0   (I0),
        .I1   (I1),
        .I2   (I2),
        .I3   (I3),
        .Gnt  (Gnt),
        .Sel  (Sel),
        .Valid(Valid),
        .S    (S)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        else
            n_pass++;
    endtask

    // Model: current owner (-1 none), priority pointer, last select,
    // number of cycles the owner has been visible.
    int m_own, m_ptr, m_sel, m_held;
    bit m_on = 1'b0;

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin
        int o, p, s, h;
        logic [3:0] oth;
        o = m_own; p = m_ptr; s = m_sel; h = m_held;
        if (rst) begin
            o = -1; p = 0; s = 0; h = 0;
        end else if (o < 0) begin
            if (Req != 4'd0) begin
                o = pick(Req, p); s = o; h = 1;
            end
        end else begin
            oth = Req & ~(4'd1 << o);
            if (!Req[o]) begin
                p = (o + 1) % 4;
                o = pick(Req, p);
                if (o >= 0) begin s = o; h = 1; end
            end else if (LIM && h >= MH && oth != 4'd0) begin
                p = (o + 1) % 4;
                o = pick(oth, p); s = o; h = 1;
            end else begin
                h = h + 1;
            end
        end
        m_own  <= o;
        m_ptr  <= p;
        m_sel  <= s;
        m_held <= h;
        m_on   <= 1'b1;
    end

    always @(negedge clk) begin
        logic [W-1:0] d [4];
        if (m_on) begin
            d[0] = I0; d[1] = I1; d[2] = I2; d[3] = I3;
            chk("m_gnt", 32'(Gnt), m_own < 0 ? 0 : (32'd1 << m_own));
            chk("m_valid", 32'(Valid), 32'(m_own >= 0));
            chk("m_sel", 32'(Sel), 32'(m_sel));
            chk("m_s", 32'(S), m_own < 0 ? 0 : 32'(d[m_sel]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [3:0] g,
                       input logic v);
        chk({nm, "_gnt"}, 32'(Gnt), 32'(g));
        chk({nm, "_valid"}, 32'(Valid), 32'(v));
    endtask

    initial begin
        rst = 1'b1; Req = 4'hF;
        I0 = 4'h7; I1 = 4'h0; I2 = 4'h0; I3 = 4'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            lit("rst", 4'h0, 1'b0);
            chk("rst_sel", 32'(Sel), 0);
            chk("rst_s", 32'(S), 0);
        end

        rst = 1'b0; Req = 4'b0100; I0 = 4'h0; I2 = 4'h1;
        tick();
        lit("single", 4'b0100, 1'b1);
        chk("single_sel", 32'(Sel), 2);
        chk("single_s", 32'(S), 1);
        Req = 4'b0000;
        tick();
        lit("drop", 4'b0000, 1'b0);
        chk("drop_sel_hold", 32'(Sel), 2);
        chk("drop_s", 32'(S), 0);

        rst = 1'b1; tick();
        rst = 1'b0;
        I0 = 4'h5; I1 = 4'hA; I2 = 4'h3; I3 = 4'hC;
        Req = 4'hF;
        tick();
        lit("rr_first", 4'b0001, 1'b1);
        chk("rr_first_s", 32'(S), 32'h5);
        for (int k = 0; k < 4; k++) begin
            tick();
            lit("rr_hold", 4'(1 << k), 1'b1);
            Req = 4'hF & ~(4'(1 << k));
            tick();
            lit("rr_next", 4'(1 << ((k + 1) % 4)), 1'b1);
            Req = 4'hF;
        end

        Req = 4'b1000;
        tick();
        lit("to3", 4'b1000, 1'b1);
        chk("to3_s", 32'(S), 32'hC);
        Req = 4'b0011;
        tick();
        lit("wrap0", 4'b0001, 1'b1);
        Req = 4'b0010;
        tick();
        lit("wrap1", 4'b0010, 1'b1);

        tick();
        lit("hold1", 4'b0010, 1'b1);
        rst = 1'b1;
        tick();
        lit("midrst", 4'b0000, 1'b0);
        chk("midrst_sel", 32'(Sel), 0);
        rst = 1'b0; Req = 4'b0000;
        tick();
        Req = 4'b0010;
        tick();
        lit("post_rst", 4'b0010, 1'b1);
        Req = 4'b0000;
        tick();
        Req = 4'b1001;
        tick();
        lit("ptr2_pick3", 4'b1000, 1'b1);
        Req = 4'b0000;
        tick();
        rst = 1'b1; tick();
        rst = 1'b0; Req = 4'b1001;
        tick();
        lit("ptr0_pick0", 4'b0001, 1'b1);

        Req = 4'b0000; tick();
        rst = 1'b1; tick();
        rst = 1'b0; Req = 4'b0101;
        tick();
        lit("lim_c1", 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("lim_hold0", 4'b0001, 1'b1);
        end
        tick();
`ifdef ARB_HOLD_LIMIT_EN
        lit("lim_revoke", 4'b0100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("lim_hold2", 4'b0100, 1'b1);
        end
        tick();
        lit("lim_back0", 4'b0001, 1'b1);
        Req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            lit("lim_sat", 4'b0001, 1'b1);
        end
        Req = 4'b0011;
        tick();
        lit("lim_sat_rev", 4'b0010, 1'b1);
`else
        lit("nolim_c5", 4'b0001, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            lit("nolim_hold", 4'b0001, 1'b1);
        end
`endif

        Req = 4'b0110; tick();
        Req = 4'b1110; tick();
        Req = 4'b0000; tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
